// File: rtl/serial_parity_rx_if.sv
// Bus bundle for serial_parity_rx: serial input strobe plus the parallel word/flag outputs.
// Optional error-counter signals exist only when PARITY_ERR_CNT_EN is defined.
interface serial_parity_rx_if #(
  parameter int unsigned DATA_W = 8
);
  logic              x;
  logic              bit_en;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              par_err;
  logic              frame_err;
  logic              busy;
`ifdef PARITY_ERR_CNT_EN
  logic              err_clr;
  logic [7:0]        err_cnt;

  modport master (
    output x, bit_en, err_clr,
    input  data, valid, par_err, frame_err, busy, err_cnt
  );
  modport slave (
    input  x, bit_en, err_clr,
    output data, valid, par_err, frame_err, busy, err_cnt
  );
`else
  modport master (
    output x, bit_en,
    input  data, valid, par_err, frame_err, busy
  );
  modport slave (
    input  x, bit_en,
    output data, valid, par_err, frame_err, busy
  );
`endif
endinterface

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start / DATA_W bits LSB-first / parity / stop, with parity and framing checks.
// Define PARITY_ERR_CNT_EN to add a saturating error counter with synchronous clear.
module serial_parity_rx #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          ODD_PARITY = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  serial_parity_rx_if.slave bus
);
  localparam int unsigned     CntW    = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  typedef enum logic [2:0] {StIdle, StData, StPar, StStop, StBreak} state_e;

  state_e            r_state, w_state_next;
  logic [CntW-1:0]   r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_data;
  logic              r_par;
  logic              r_mis;
  logic              r_valid;
  logic              r_par_err;
  logic              r_frame_err;
  logic              w_start;
  logic              w_shift;
  logic              w_par_sample;
  logic              w_stop_sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_start       = 1'b0;
    w_shift       = 1'b0;
    w_par_sample  = 1'b0;
    w_stop_sample = 1'b0;
    if (bus.bit_en) begin
      case (r_state)
        StIdle: begin
          if (!bus.x) begin
            w_start      = 1'b1;
            w_state_next = StData;
          end
        end
        StData: begin
          w_shift = 1'b1;
          if (r_cnt == LastBit) w_state_next = StPar;
        end
        StPar: begin
          w_par_sample = 1'b1;
          w_state_next = StStop;
        end
        StStop: begin
          w_stop_sample = 1'b1;
          w_state_next  = bus.x ? StIdle : StBreak;
        end
        // A line held low must return high before a new start bit is honoured.
        StBreak: begin
          if (bus.x) w_state_next = StIdle;
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_par       <= 1'b0;
      r_mis       <= 1'b0;
      r_valid     <= 1'b0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid     <= w_stop_sample;
      r_par_err   <= w_stop_sample & r_mis;
      r_frame_err <= w_stop_sample & ~bus.x;
      if (w_start) begin
        r_cnt <= '0;
        r_par <= 1'b0;
      end
      if (w_shift) begin
        r_shift <= {bus.x, r_shift[DATA_W-1:1]};
        r_par   <= r_par ^ bus.x;
        r_cnt   <= r_cnt + 1'b1;
      end
      if (w_par_sample)  r_mis  <= bus.x ^ r_par ^ ODD_PARITY;
      if (w_stop_sample) r_data <= r_shift;
    end
  end

  assign bus.data      = r_data;
  assign bus.valid     = r_valid;
  assign bus.par_err   = r_par_err;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state != StIdle);

`ifdef PARITY_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  // Counts in the cycle the flagged valid is presented; clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (bus.err_clr) begin
      r_err_cnt <= '0;
    end else if (r_valid && (r_par_err || r_frame_err) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.err_cnt = r_err_cnt;
`endif
endmodule

// File: tb/tb_serial_parity_rx.sv
// Scoreboard bench for serial_parity_rx: an even-parity and an odd-parity instance share clock/reset.
module tb_serial_parity_rx;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_parity_rx_if #(.DATA_W(8)) bus_e ();
  serial_parity_rx_if #(.DATA_W(8)) bus_o ();

  serial_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b0)) dut_e (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_e)
  );

  serial_parity_rx #(.DATA_W(8), .ODD_PARITY(1'b1)) dut_o (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_o)
  );

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    int         cyc;
  } exp_t;

  exp_t       q_e[$];
  exp_t       q_o[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         nvalid[2];
  logic [7:0] hold[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int s, input logic v, input logic [7:0] d, input logic pe,
                     input logic fe);
    exp_t e;
    int   qs;
    qs = (s == 0) ? q_e.size() : q_o.size();
    if (v === 1'b1) begin
      nvalid[s]++;
      if (qs == 0) begin
        checks++;
        errors++;
        $display("FAIL dut%0d_unexpected_valid: got valid=1 data=0x%0h, expected no frame", s, d);
      end else begin
        if (s == 0) e = q_e.pop_front();
        else        e = q_o.pop_front();
        chk($sformatf("dut%0d_data", s), 32'(d), 32'(e.data));
        chk($sformatf("dut%0d_par_err", s), 32'(pe), 32'(e.pe));
        chk($sformatf("dut%0d_frame_err", s), 32'(fe), 32'(e.fe));
        chk($sformatf("dut%0d_latency_cycle", s), 32'(cyc), 32'(e.cyc));
        hold[s] = e.data;
      end
    end else begin
      chk($sformatf("dut%0d_flags_idle", s), 32'({pe, fe}), 32'd0);
      chk($sformatf("dut%0d_data_hold", s), 32'(d), 32'(hold[s]));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      mon(0, bus_e.valid, bus_e.data, bus_e.par_err, bus_e.frame_err);
      mon(1, bus_o.valid, bus_o.data, bus_o.par_err, bus_o.frame_err);
    end else begin
      hold[0] = 8'h00;
      hold[1] = 8'h00;
    end
  end

  task automatic strobe(input int s, input logic b);
    if (s == 0) begin
      bus_e.x      = b;
      bus_e.bit_en = 1'b1;
    end else begin
      bus_o.x      = b;
      bus_o.bit_en = 1'b1;
    end
    @(posedge clk);
    #1;
    bus_e.bit_en = 1'b0;
    bus_o.bit_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected flags are passed in hand-computed; vary inserts 0..3 idle cycles between bits.
  task automatic send_frame(input int s, input logic [7:0] d, input logic pb, input logic sb,
                            input logic epe, input logic efe, input bit vary);
    exp_t e;
    int   k = 0;
    strobe(s, 1'b0);
    if (vary) idle(k % 4);
    k++;
    for (int i = 0; i < 8; i++) begin
      strobe(s, d[i]);
      if (vary) idle(k % 4);
      k++;
    end
    strobe(s, pb);
    if (vary) idle(k % 4);
    strobe(s, sb);
    e.data = d;
    e.pe   = epe;
    e.fe   = efe;
    e.cyc  = cyc;
    if (s == 0) q_e.push_back(e);
    else        q_o.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    nvalid[0]    = 0;
    nvalid[1]    = 0;
    hold[0]      = 8'h00;
    hold[1]      = 8'h00;
    bus_e.x      = 1'b1;
    bus_e.bit_en = 1'b0;
    bus_o.x      = 1'b1;
    bus_o.bit_en = 1'b0;
`ifdef PARITY_ERR_CNT_EN
    bus_e.err_clr = 1'b0;
    bus_o.err_clr = 1'b0;
`endif
    rst_n = 1'b0;
    idle(3);
    chk("rst_valid", 32'(bus_e.valid), 32'd0);
    chk("rst_data", 32'(bus_e.data), 32'd0);
    chk("rst_busy", 32'(bus_e.busy), 32'd0);
    chk("rst_flags", 32'({bus_e.par_err, bus_e.frame_err}), 32'd0);
    chk("rst_busy_odd", 32'(bus_o.busy), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // A5 has four ones: even parity bit 0 is correct, 1 is a mismatch.
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("busy_after_frame", 32'(bus_e.busy), 32'd0);
    send_frame(0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
`ifdef PARITY_ERR_CNT_EN
    chk("err_cnt_one", 32'(bus_e.err_cnt), 32'd1);
`endif

    // 07 has XOR=1, so odd parity expects bit 0.
    send_frame(1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Framing error, then line held low: no frame may start until it goes high.
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (5) strobe(0, 1'b0);
    chk("busy_in_break", 32'(bus_e.busy), 32'd1);
    strobe(0, 1'b1);
    chk("idle_after_break", 32'(bus_e.busy), 32'd0);
    send_frame(0, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Reset partway through the data bits.
    strobe(0, 1'b0);
    for (int i = 0; i < 4; i++) strobe(0, 1'b1);
    chk("busy_mid_frame", 32'(bus_e.busy), 32'd1);
    #2 rst_n = 1'b0;
    #3;
    chk("rst_mid_data", 32'(bus_e.data), 32'd0);
    chk("rst_mid_busy", 32'(bus_e.busy), 32'd0);
    rst_n = 1'b1;
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Back-to-back frames with irregular strobe gaps.
    n0 = nvalid[0];
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);
    chk("b2b_valid_count", 32'(nvalid[0] - n0), 32'd2);

`ifdef PARITY_ERR_CNT_EN
    bus_e.err_clr = 1'b1;
    idle(1);
    bus_e.err_clr = 1'b0;
    chk("err_cnt_cleared", 32'(bus_e.err_cnt), 32'd0);
    // 01 has one set bit, so even parity bit 0 is a mismatch.
    repeat (300) send_frame(0, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("err_cnt_saturated", 32'(bus_e.err_cnt), 32'd255);
    bus_e.err_clr = 1'b1;
    idle(1);
    bus_e.err_clr = 1'b0;
    chk("err_cnt_after_clr", 32'(bus_e.err_cnt), 32'd0);
`endif

    idle(3);
    chk("dut0_missing_valids", 32'(q_e.size()), 32'd0);
    chk("dut1_missing_valids", 32'(q_o.size()), 32'd0);
    chk("dut1_valid_total", 32'(nvalid[1]), 32'd2);
`ifdef PARITY_ERR_CNT_EN
    chk("dut0_valid_total", 32'(nvalid[0]), 32'd307);
`else
    chk("dut0_valid_total", 32'(nvalid[0]), 32'd7);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_parity_rx.md
Name: serial_parity_rx

Overview:
Serial frame receiver that sits downstream of the running even/odd parity FSM in the serial datapath. It frames a bit-serial stream into start / DATA_W data bits / parity bit / stop. It checks the parity bit against an internally tracked running parity and the stop bit. It presents each word in parallel with a one-cycle valid strobe and error flags.

Parameters:
DATA_W, 8, number of data bits per frame (2..32), LSB first
ODD_PARITY, 0, 0 = even parity (expected parity bit = XOR of data bits), 1 = odd parity (expected = ~XOR)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
x  input  1  serial data bit, sampled only when bit_en=1
bit_en  input  1  bit strobe; one serial bit per cycle with bit_en=1
data  output  DATA_W  last received word; held until next valid
valid  output  1  one-cycle pulse, frame complete
par_err  output  1  parity mismatch for the frame; qualified by valid
frame_err  output  1  stop bit was 0; qualified by valid
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0, async): state=IDLE, data=0, valid=0, par_err=0, frame_err=0, busy=0, bit counter=0, running parity=0. Reset mid-frame discards the partial word; no valid is issued.
- bit_en=0: state, counter, shift register and parity hold; valid/par_err/frame_err deassert.
- States:
  - IDLE: on bit_en with x=0 (start bit), go to DATA; clear counter and running parity. On bit_en with x=1, stay in IDLE.
  - DATA: on each bit_en, shift x into the shift register at the MSB and shift right, so the first bit lands at bit 0 after DATA_W bits. Update running parity ^= x. Increment the counter. After the DATA_W-th bit, go to PAR.
  - PAR: on bit_en, latch mismatch = x ^ running_parity ^ ODD_PARITY. Go to STOP.
  - STOP: on bit_en, in the next cycle: valid=1, data=shift register, par_err=latched mismatch, frame_err=~x.
    - If x=1, go to IDLE.
    - If x=0, go to BREAK.
  - BREAK: stay here until bit_en with x=1, then go to IDLE. A held-low line never starts a new frame.
- Latency: valid is registered and rises exactly one clk after the edge that samples the stop bit.
- data updates only on valid. Between frames data holds its value; par_err and frame_err are 0 whenever valid=0.
- A start bit is accepted on the bit_en immediately following the stop bit, so back-to-back frames have no idle gap.
- Counter width is clog2(DATA_W+1). Wrap is impossible because the counter clears in IDLE.

Optional Feature:
Macro PARITY_ERR_CNT_EN.
- Defined:
  - Adds input err_clr (1 bit, synchronous clear) and output err_cnt (8 bits).
  - err_cnt increments on each valid with par_err|frame_err=1 and saturates at 255.
  - err_cnt resets to 0 on rst_n=0 or err_clr=1.
  - If err_clr and an error valid occur in the same cycle, clear wins.
- Not defined: these ports and the counter logic do not exist. All other behaviour is identical.

Test Plan:
- Even parity, DATA_W=8, bits 0, A5 LSB-first, 0, 1 (parity bit 0, stop 1) -> valid 1 cycle after stop, data=0xA5, par_err=0, frame_err=0, busy returns 0.
- Same frame with parity bit 1 -> data=0xA5, par_err=1, frame_err=0; with PARITY_ERR_CNT_EN, err_cnt=1.
- ODD_PARITY=1, data 0x07 (XOR=1), parity bit 0 -> par_err=0; parity bit 1 -> par_err=1.
- Stop bit 0 on data 0x3C, then x held 0 for 5 strobes, then x=1, then a valid frame 0x81 -> first frame valid with frame_err=1; no frame starts during the low period; second frame valid with data=0x81 and no errors.
- rst_n pulsed low after 4 data bits, then a full frame 0x5A -> no valid for the partial frame; data=0x00 until the frame completes; then data=0x5A.
- Back-to-back frames 0x11, 0xEE with bit_en gaps of 0-3 cycles -> exactly two valid pulses with correct data. Gaps do not alter state. With PARITY_ERR_CNT_EN: 300 error frames -> err_cnt=255; err_clr -> 0.
